pll_reconfig_ctrl: RTL and testbench

Sequencer that owns the dynamic-divider, reset and clock-enable ports of a GW5A PLL. It is the parametrised successor to the fixed-divider PLL wrapper used by the SDRAM test: boot dividers become parameters, the channel count is generic, and dividers can be reprogrammed at run time through a valid/ready handshake. It waits for lock with a timeout and retry, detects loss of lock, and gates the output clocks while the PLL is not stable. It runs in the free-running PLL input-clock domain, not on a PLL output.

---
 rtl/pll_reconfig_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_ctrl.sv
// GW5A PLL sequencer: boot/run-time divider programming, lock wait
// with timeout/retry, loss-of-lock recovery and output clock gating.
module pll_reconfig_ctrl #(
  parameter int                  NUM_CH       = 3,
  parameter logic [5:0]          DEF_IDSEL    = 6'd3,
  parameter logic [5:0]          DEF_FBDSEL   = 6'd1,
  parameter logic [6:0]          DEF_MDSEL    = 7'd38,
  parameter logic [NUM_CH*7-1:0] DEF_ODSEL    = {7'd20, 7'd20, 7'd5},
  parameter int                  RST_CYC      = 16,
  parameter int                  LOCK_STABLE  = 256,
  parameter int                  LOCK_TIMEOUT = 65536,
  parameter int                  MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [5:0]            cfg_idsel,
  input  logic [5:0]            cfg_fbdsel,
  input  logic [6:0]            cfg_mdsel,
  input  logic [NUM_CH*7-1:0]   cfg_odsel,
  output logic                  cfg_nack,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic [5:0]            pll_idsel,
  output logic [5:0]            pll_fbdsel,
  output logic [6:0]            pll_mdsel,
  output logic [NUM_CH*7-1:0]   pll_odsel,
  output logic [NUM_CH-1:0]     pll_enclk,
  output logic                  locked,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            retry_cnt,
  output logic [7:0]            loss_cnt
);

  localparam logic [2:0] S_GATE     = 3'd0;
  localparam logic [2:0] S_RSTHOLD  = 3'd1;
  localparam logic [2:0] S_WAITLOCK = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_FAIL     = 3'd4;

  localparam int PW = (RST_CYC > 2) ? $clog2(RST_CYC) : 1;
  localparam int TW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [1:0]    retry_n;
  logic [PW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [SW-1:0] stab;
  logic          sync1;
  logic          lock_s;
  logic          odsel_bad;
  logic          cfg_bad;
  logic          loss;
  logic          req;
  logic          accept;
  logic          reject;
  logic          stab_hit;
  logic          tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
    end
  end

  always_comb begin
    odsel_bad = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_odsel[i*7 +: 7] == 7'd0) odsel_bad = 1'b1;
    end
  end

  assign cfg_bad  = (cfg_idsel == 6'd0) || (cfg_mdsel == 7'd0) || odsel_bad;
  // loss of lock in RUN takes priority over a request in the same cycle
  assign loss     = (state == S_RUN) && !lock_s;
  assign req      = cfg_valid && cfg_ready && !loss;
  assign accept   = req && !cfg_bad;
  assign reject   = req && cfg_bad;
  assign stab_hit = lock_s && (stab == SW'(LOCK_STABLE - 1));
  assign tmo_hit  = (tmo == TW'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    unique case (state)
      S_GATE: begin
        if (cnt == PW'(1)) state_n = S_RSTHOLD;
      end
      S_RSTHOLD: begin
        if (cnt == PW'(RST_CYC - 1)) state_n = S_WAITLOCK;
      end
      S_WAITLOCK: begin
        if (stab_hit) begin
          state_n = S_RUN;
          retry_n = 2'd0;
        end else if (tmo_hit) begin
          retry_n = retry_cnt + 2'd1;
          if (int'(retry_cnt) + 1 >= MAX_RETRY) state_n = S_FAIL;
          else state_n = S_RSTHOLD;
        end
      end
      S_RUN: begin
        if (loss) state_n = S_WAITLOCK;
      end
      S_FAIL: begin
        state_n = S_FAIL;
      end
      default: state_n = S_RSTHOLD;
    endcase
    if (accept) begin
      state_n = S_GATE;
      retry_n = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RSTHOLD;
      cnt        <= '0;
      tmo        <= '0;
      stab       <= '0;
      retry_cnt  <= 2'd0;
      loss_cnt   <= 8'd0;
      cfg_nack   <= 1'b0;
      pll_idsel  <= DEF_IDSEL;
      pll_fbdsel <= DEF_FBDSEL;
      pll_mdsel  <= DEF_MDSEL;
      pll_odsel  <= DEF_ODSEL;
      pll_reset  <= 1'b1;
      pll_enclk  <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b1;
      err        <= 1'b0;
    end else begin
      state     <= state_n;
      retry_cnt <= retry_n;
      cfg_nack  <= reject;
      if (state_n != state) begin
        cnt  <= '0;
        tmo  <= '0;
        stab <= '0;
      end else begin
        cnt  <= cnt + PW'(1);
        tmo  <= tmo + TW'(1);
        stab <= lock_s ? stab + SW'(1) : '0;
      end
      if (loss && loss_cnt != 8'hff) loss_cnt <= loss_cnt + 8'd1;
      if (accept) begin
        pll_idsel  <= cfg_idsel;
        pll_fbdsel <= cfg_fbdsel;
        pll_mdsel  <= cfg_mdsel;
        pll_odsel  <= cfg_odsel;
      end
      // outputs follow the next state so they are glitch-free registers
      pll_reset <= (state_n == S_RSTHOLD) || (state_n == S_FAIL);
      pll_enclk <= {NUM_CH{state_n == S_RUN}};
      locked    <= (state_n == S_RUN);
      cfg_ready <= (state_n == S_RUN) || (state_n == S_FAIL);
      busy      <= !((state_n == S_RUN) || (state_n == S_FAIL));
      err       <= (state_n == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Randomized bench for pll_reconfig_ctrl with an event-timing
// reference model derived from the sequencing rules.
module tb_pll_reconfig_ctrl;
  localparam int NUM_CH = 3;
  localparam int RST_CYC = 4;
  localparam int LOCK_STABLE = 8;
  localparam int LOCK_TIMEOUT = 64;
  localparam int MAX_RETRY = 3;
  localparam logic [5:0] D_ID = 6'd3;
  localparam logic [5:0] D_FB = 6'd1;
  localparam logic [6:0] D_MD = 7'd38;
  localparam logic [20:0] D_OD = {7'd20, 7'd20, 7'd5};
  localparam int LOCK_LAT = 2 + LOCK_STABLE;

  logic clk, rst;
  logic cfg_valid, cfg_ready, cfg_nack;
  logic [5:0] cfg_idsel, cfg_fbdsel;
  logic [6:0] cfg_mdsel;
  logic [20:0] cfg_odsel;
  logic pll_lock, pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel;
  logic [6:0] pll_mdsel;
  logic [20:0] pll_odsel;
  logic [2:0] pll_enclk;
  logic locked, busy, err;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int total = 0;
  int bad = 0;

  logic [5:0] m_id, m_fb;
  logic [6:0] m_md;
  logic [20:0] m_od;
  int m_loss;

  pll_reconfig_ctrl #(
    .NUM_CH(NUM_CH), .DEF_IDSEL(D_ID), .DEF_FBDSEL(D_FB),
    .DEF_MDSEL(D_MD), .DEF_ODSEL(D_OD), .RST_CYC(RST_CYC),
    .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_idsel(cfg_idsel),
    .cfg_fbdsel(cfg_fbdsel), .cfg_mdsel(cfg_mdsel),
    .cfg_odsel(cfg_odsel), .cfg_nack(cfg_nack),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
    .pll_mdsel(pll_mdsel), .pll_odsel(pll_odsel),
    .pll_enclk(pll_enclk), .locked(locked), .busy(busy),
    .err(err), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_rst(input logic val, input int maxc, output int n);
    n = 0;
    while (pll_reset !== val && n < maxc) begin
      tick();
      n++;
    end
    if (pll_reset !== val) n = -1;
  endtask

  task automatic wait_locked(input int maxc, output int n, output bit rs);
    n = 0;
    rs = 1'b0;
    while (locked !== 1'b1 && n < maxc) begin
      tick();
      n++;
      if (pll_reset === 1'b1) rs = 1'b1;
    end
    if (locked !== 1'b1) n = -1;
  endtask

  task automatic rand_cfg();
    cfg_idsel = 6'($urandom_range(1, 63));
    cfg_fbdsel = 6'($urandom_range(0, 63));
    cfg_mdsel = 7'($urandom_range(1, 127));
    for (int i = 0; i < NUM_CH; i++)
      cfg_odsel[i*7 +: 7] = 7'($urandom_range(1, 127));
  endtask

  task automatic model_accept();
    m_id = cfg_idsel;
    m_fb = cfg_fbdsel;
    m_md = cfg_mdsel;
    m_od = cfg_odsel;
  endtask

  task automatic model_boot();
    m_id = D_ID;
    m_fb = D_FB;
    m_md = D_MD;
    m_od = D_OD;
    m_loss = 0;
  endtask

  task automatic test_reset();
    int n;
    bit rs;
    rst = 1'b1;
    pll_lock = 1'b0;
    cfg_valid = 1'b0;
    cfg_idsel = '0;
    cfg_fbdsel = '0;
    cfg_mdsel = '0;
    cfg_odsel = '0;
    model_boot();
    ticks(3);
    total++;
    if (pll_reset !== 1'b1 || pll_enclk !== 3'b000) begin
      bad++;
      $display("FAIL rst_pll got=%b/%b exp=1/000", pll_reset, pll_enclk);
    end
    total++;
    if ({pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel} !== {m_id, m_fb, m_md, m_od}) begin
      bad++;
      $display("FAIL rst_sel got=%0h exp=%0h", {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, {m_id, m_fb, m_md, m_od});
    end
    total++;
    if ({locked, cfg_ready, cfg_nack, busy, err} !== 5'b00010) begin
      bad++;
      $display("FAIL rst_stat got=%b exp=00010", {locked, cfg_ready, cfg_nack, busy, err});
    end
    total++;
    if (retry_cnt !== 2'd0 || loss_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d/%0d exp=0/0", retry_cnt, loss_cnt);
    end
    rst = 1'b0;
    wait_rst(1'b0, 50, n);
    total++;
    if (n !== RST_CYC) begin
      bad++;
      $display("FAIL boot_rst_len got=%0d exp=%0d", n, RST_CYC);
    end
    ticks(10 - RST_CYC);
    pll_lock = 1'b1;
    wait_locked(100, n, rs);
    total++;
    if (n !== LOCK_LAT) begin
      bad++;
      $display("FAIL boot_lock_lat got=%0d exp=%0d", n, LOCK_LAT);
    end
    total++;
    if (pll_enclk !== 3'b111 || pll_mdsel !== 7'd38 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL boot_run got=%b/%0d/%b/%b exp=111/38/0/1", pll_enclk, pll_mdsel, busy, cfg_ready);
    end
  endtask

  task automatic test_reconfig();
    int n1, n2, n3;
    bit rs;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        cfg_idsel = D_ID;
        cfg_fbdsel = D_FB;
        cfg_mdsel = 7'd50;
        cfg_odsel = {7'd10, 7'd10, 7'd4};
      end else begin
        rand_cfg();
      end
      cfg_valid = 1'b1;
      model_accept();
      tick();
      cfg_valid = 1'b0;
      pll_lock = 1'b0;
      total++;
      if (pll_enclk !== 3'b000 || locked !== 1'b0) begin
        bad++;
        $display("FAIL rcfg_gate got=%b/%b exp=000/0", pll_enclk, locked);
      end
      total++;
      if ({pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel} !== {m_id, m_fb, m_md, m_od}) begin
        bad++;
        $display("FAIL rcfg_sel got=%0h exp=%0h", {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, {m_id, m_fb, m_md, m_od});
      end
      wait_rst(1'b1, 20, n1);
      total++;
      if (n1 !== 2) begin
        bad++;
        $display("FAIL rcfg_gate_len got=%0d exp=2", n1);
      end
      wait_rst(1'b0, 50, n2);
      total++;
      if (n2 !== RST_CYC) begin
        bad++;
        $display("FAIL rcfg_rst_len got=%0d exp=%0d", n2, RST_CYC);
      end
      pll_lock = 1'b1;
      wait_locked(100, n3, rs);
      total++;
      if (n3 < 0 || n1 + n2 + n3 !== 2 + RST_CYC + 2 + LOCK_STABLE) begin
        bad++;
        $display("FAIL rcfg_latency got=%0d exp=%0d", n1 + n2 + n3, 2 + RST_CYC + 2 + LOCK_STABLE);
      end
      total++;
      if (pll_enclk !== 3'b111 || pll_odsel !== m_od) begin
        bad++;
        $display("FAIL rcfg_run got=%b/%0h exp=111/%0h", pll_enclk, pll_odsel, m_od);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    bit rs;
    rand_cfg();
    cfg_valid = 1'b1;
    model_accept();
    tick();
    cfg_valid = 1'b0;
    pll_lock = 1'b0;
    for (int i = 1; i <= MAX_RETRY; i++) begin
      wait_rst(1'b1, 20, n);
      total++;
      if (n !== ((i == 1) ? 2 : 0)) begin
        bad++;
        $display("FAIL tmo_rst_rise%0d got=%0d exp=%0d", i, n, (i == 1) ? 2 : 0);
      end
      wait_rst(1'b0, 50, n);
      total++;
      if (n !== RST_CYC) begin
        bad++;
        $display("FAIL tmo_rst_len%0d got=%0d exp=%0d", i, n, RST_CYC);
      end
      ticks(LOCK_TIMEOUT - 1);
      total++;
      if (retry_cnt !== 2'(i - 1) || pll_reset !== 1'b0) begin
        bad++;
        $display("FAIL tmo_pre%0d got=%0d/%b exp=%0d/0", i, retry_cnt, pll_reset, i - 1);
      end
      tick();
      total++;
      if (retry_cnt !== 2'(i) || pll_reset !== 1'b1) begin
        bad++;
        $display("FAIL tmo_post%0d got=%0d/%b exp=%0d/1", i, retry_cnt, pll_reset, i);
      end
      total++;
      if (err !== (i == MAX_RETRY) || cfg_ready !== (i == MAX_RETRY)) begin
        bad++;
        $display("FAIL tmo_err%0d got=%b/%b exp=%b", i, err, cfg_ready, i == MAX_RETRY);
      end
    end
    total++;
    if (busy !== 1'b0 || locked !== 1'b0 || pll_enclk !== 3'b000) begin
      bad++;
      $display("FAIL fail_stat got=%b/%b/%b exp=0/0/000", busy, locked, pll_enclk);
    end
    rand_cfg();
    cfg_mdsel = 7'd0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    total++;
    if (cfg_nack !== 1'b1 || err !== 1'b1 || pll_mdsel !== m_md) begin
      bad++;
      $display("FAIL fail_reject got=%b/%b/%0d exp=1/1/%0d", cfg_nack, err, pll_mdsel, m_md);
    end
    rand_cfg();
    cfg_valid = 1'b1;
    model_accept();
    tick();
    cfg_valid = 1'b0;
    total++;
    if (err !== 1'b0 || retry_cnt !== 2'd0 || busy !== 1'b1 || cfg_nack !== 1'b0) begin
      bad++;
      $display("FAIL fail_clear got=%b/%0d/%b/%b exp=0/0/1/0", err, retry_cnt, busy, cfg_nack);
    end
    wait_rst(1'b1, 20, n);
    wait_rst(1'b0, 50, n);
    pll_lock = 1'b1;
    wait_locked(100, n, rs);
    total++;
    if (n !== LOCK_LAT || pll_mdsel !== m_md) begin
      bad++;
      $display("FAIL fail_relock got=%0d/%0d exp=%0d/%0d", n, pll_mdsel, LOCK_LAT, m_md);
    end
  endtask

  task automatic test_reject();
    int ch;
    for (int v = 0; v < 3; v++) begin
      rand_cfg();
      if (v == 0) cfg_mdsel = 7'd0;
      else if (v == 1) cfg_idsel = 6'd0;
      else begin
        ch = int'($urandom_range(0, NUM_CH - 1));
        cfg_odsel[ch*7 +: 7] = 7'd0;
      end
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      total++;
      if (cfg_nack !== 1'b1 || locked !== 1'b1) begin
        bad++;
        $display("FAIL rej_nack%0d got=%b/%b exp=1/1", v, cfg_nack, locked);
      end
      total++;
      if ({pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel} !== {m_id, m_fb, m_md, m_od}) begin
        bad++;
        $display("FAIL rej_sel%0d got=%0h exp=%0h", v, {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, {m_id, m_fb, m_md, m_od});
      end
      tick();
      total++;
      if (cfg_nack !== 1'b0 || locked !== 1'b1) begin
        bad++;
        $display("FAIL rej_pulse%0d got=%b/%b exp=0/1", v, cfg_nack, locked);
      end
    end
  endtask

  task automatic test_simultaneous();
    int n;
    bit rs;
    pll_lock = 1'b0;
    ticks(2);
    rand_cfg();
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    m_loss++;
    total++;
    if (locked !== 1'b0 || cfg_ready !== 1'b0 || cfg_nack !== 1'b0) begin
      bad++;
      $display("FAIL sim_state got=%b/%b/%b exp=0/0/0", locked, cfg_ready, cfg_nack);
    end
    total++;
    if ({pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel} !== {m_id, m_fb, m_md, m_od} || loss_cnt !== 8'(m_loss)) begin
      bad++;
      $display("FAIL sim_sel got=%0h/%0d exp=%0h/%0d", {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, loss_cnt, {m_id, m_fb, m_md, m_od}, m_loss);
    end
    pll_lock = 1'b1;
    wait_locked(100, n, rs);
    total++;
    if (n !== LOCK_LAT || rs) begin
      bad++;
      $display("FAIL sim_relock got=%0d/%b exp=%0d/0", n, rs, LOCK_LAT);
    end
  endtask

  task automatic test_loss();
    int n, d;
    bit rs;
    pll_lock = 1'b0;
    tick();
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL loss_sync got=%b exp=1", locked);
    end
    ticks(2);
    m_loss++;
    total++;
    if (locked !== 1'b0 || pll_enclk !== 3'b000 || pll_reset !== 1'b0 || loss_cnt !== 8'(m_loss)) begin
      bad++;
      $display("FAIL loss_drop got=%b/%b/%b/%0d exp=0/000/0/%0d", locked, pll_enclk, pll_reset, loss_cnt, m_loss);
    end
    pll_lock = 1'b1;
    wait_locked(100, n, rs);
    total++;
    if (n !== LOCK_LAT || rs || pll_mdsel !== m_md) begin
      bad++;
      $display("FAIL loss_relock got=%0d/%b exp=%0d/0", n, rs, LOCK_LAT);
    end
    for (int k = 0; k < 300; k++) begin
      d = int'($urandom_range(3, 5));
      pll_lock = 1'b0;
      ticks(d);
      pll_lock = 1'b1;
      if (m_loss < 255) m_loss++;
      wait_locked(100, n, rs);
      total++;
      if (n !== LOCK_LAT || rs) begin
        bad++;
        $display("FAIL loss_loop%0d got=%0d/%b exp=%0d/0", k, n, rs, LOCK_LAT);
      end
    end
    total++;
    if (loss_cnt !== 8'(m_loss) || m_loss != 255) begin
      bad++;
      $display("FAIL loss_sat got=%0d exp=%0d", loss_cnt, m_loss);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    rand_cfg();
    cfg_valid = 1'b1;
    model_accept();
    tick();
    cfg_valid = 1'b0;
    pll_lock = 1'b0;
    wait_rst(1'b1, 20, n);
    wait_rst(1'b0, 50, n);
    ticks(LOCK_TIMEOUT);
    wait_rst(1'b0, 50, n);
    ticks(3);
    total++;
    if (retry_cnt !== 2'd1 || pll_mdsel !== m_md || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got=%0d/%0d/%b exp=1/%0d/1", retry_cnt, pll_mdsel, busy, m_md);
    end
    #3;
    rst = 1'b1;
    model_boot();
    #1;
    total++;
    if ({pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel} !== {m_id, m_fb, m_md, m_od}) begin
      bad++;
      $display("FAIL abort_sel got=%0h exp=%0h", {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, {m_id, m_fb, m_md, m_od});
    end
    total++;
    if (retry_cnt !== 2'd0 || loss_cnt !== 8'd0 || pll_reset !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_stat got=%0d/%0d/%b/%b exp=0/0/1/1", retry_cnt, loss_cnt, pll_reset, busy);
    end
    ticks(2);
    rst = 1'b0;
    ticks(2);
  endtask

  initial begin
    test_reset();
    test_reconfig();
    test_timeout();
    test_reject();
    test_simultaneous();
    test_loss();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
